// File: rtl/lsu.sv
// Load/store unit: turns byte/half/word CPU requests into whole-word bram accesses,
// using read-modify-write for sub-word stores and rejecting misaligned or illegal sizes.
`timescale 1ns/1ps

module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [12:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        mem_rd_en,
    output logic [12:0] mem_addr,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_valid,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        RSP
    } state_t;

    state_t      state;
    logic        lat_we;
    logic [1:0]  lat_low;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_wdata;

    function automatic logic is_bad_request(input logic [1:0] size, input logic [1:0] low);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = low[0];
            2'd2:    bad = |low;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Shift the addressed lane down to bit 0 and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] data,
                                                 input logic [1:0]  low,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        lane_b = data[{low, 3'b000} +: 8];
        lane_h = data[{low[1], 4'b0000} +: 16];
        case (size)
            2'd0:    result = {{24{~uns & lane_b[7]}}, lane_b};
            2'd1:    result = {{16{~uns & lane_h[15]}}, lane_h};
            default: result = data;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] data,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  low,
                                                input logic [1:0]  size);
        logic [31:0] result;
        result = data;
        case (size)
            2'd0:    result[{low, 3'b000} +: 8]     = wdata[7:0];
            2'd1:    result[{low[1], 4'b0000} +: 16] = wdata[15:0];
            default: result = wdata;
        endcase
        return result;
    endfunction

    // Every output is a register updated alongside the state, so nothing on
    // the req_* inputs can reach mem_* or rsp_* within the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= 32'd0;
            mem_rd_en    <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_addr     <= 13'd0;
            mem_wr_data  <= 32'd0;
            lat_we       <= 1'b0;
            lat_low      <= 2'd0;
            lat_size     <= 2'd0;
            lat_unsigned <= 1'b0;
            lat_wdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Coming out of reset the unit spends one cycle idle but not ready.
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        req_ready    <= 1'b0;
                        lat_we       <= req_we;
                        lat_low      <= req_addr[1:0];
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_wdata    <= req_wdata;
                        if (is_bad_request(req_size, req_addr[1:0])) begin
                            state     <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            mem_addr <= {req_addr[12:2], 2'b00};
                            if (req_we && (req_size == 2'd2)) begin
                                state       <= WR;
                                mem_wr_en   <= 1'b1;
                                mem_wr_data <= req_wdata;
                            end else begin
                                state     <= RD;
                                mem_rd_en <= 1'b1;
                            end
                        end
                    end
                end
                RD: begin
                    mem_rd_en <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (mem_rd_valid) begin
                        if (lat_we) begin
                            mem_wr_data <= merge_store(mem_rd_data, lat_wdata, lat_low, lat_size);
                            mem_wr_en   <= 1'b1;
                            state       <= WR;
                        end else begin
                            rsp_rdata <= extract_load(mem_rd_data, lat_low, lat_size, lat_unsigned);
                            rsp_valid <= 1'b1;
                            state     <= RSP;
                        end
                    end
                end
                WR: begin
                    mem_wr_en <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= 32'd0;
                    state     <= RSP;
                end
                RSP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    mem_rd_en <= 1'b0;
                    mem_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: bram model with adjustable read latency, directed cases
// from the intended behaviour, then random traffic against a word-array reference.
`timescale 1ns/1ps

module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [12:0] req_addr = 13'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_rd_en;
    logic [12:0] mem_addr;
    logic [31:0] mem_rd_data = 32'd0;
    logic        mem_rd_valid = 1'b0;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;

    int passed = 0;
    int total  = 0;
    int extra_lat = 0;

    logic [31:0] last_rdata;
    logic [31:0] last_wdata;
    logic        last_err;

    logic [31:0] refmem [0:2047];

    lsu dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int idx);
        return (idx * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // bram stand-in: read data lands extra_lat cycles later than the plain one-cycle memory.
    logic [31:0] mem [0:2047];
    logic        mem_init_done = 1'b0;
    logic        pending = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_word = 32'd0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 2048; i++) mem[i] <= initWord(i);
            mem_init_done <= 1'b1;
        end else if (mem_wr_en) begin
            mem[mem_addr[12:2]] <= mem_wr_data;
        end
        mem_rd_valid <= 1'b0;
        mem_rd_data  <= $urandom;
        if (rst) begin
            pending <= 1'b0;
        end else if (mem_rd_en) begin
            if (extra_lat == 0) begin
                mem_rd_valid <= 1'b1;
                mem_rd_data  <= mem[mem_addr[12:2]];
            end else begin
                pending   <= 1'b1;
                pend_cnt  <= extra_lat - 1;
                pend_word <= mem[mem_addr[12:2]];
            end
        end else if (pending) begin
            if (pend_cnt == 0) begin
                mem_rd_valid <= 1'b1;
                mem_rd_data  <= pend_word;
                pending      <= 1'b0;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end
    end

    function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [12:0] addr,
                                            input logic [1:0] size, input logic uns);
        int sh;
        logic [31:0] v;
        if (size == 2'd0) begin
            sh = 8 * int'(addr[1:0]);
            v  = (word >> sh) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            sh = 16 * int'(addr[1]);
            v  = (word >> sh) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] refStore(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [12:0] addr, input logic [1:0] size);
        int sh;
        logic [31:0] mask;
        if (size == 2'd2) return wdata;
        sh   = (size == 2'd0) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
        mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (word & ~mask) | ((wdata << sh) & mask);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic applyStimulus(input logic we, input logic [12:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata, input int extra);
        logic        err;
        logic [31:0] word, exp_rdata, exp_wdata;
        logic [12:0] exp_maddr, addr_obs;
        int          exp_rsp, exp_rd, exp_wr, exp_wr_cyc;
        int          rd_seen = 0, wr_seen = 0, rsp_cyc = -1, wr_cyc = -1;
        logic [31:0] got_wd = 32'd0, got_rd = 32'd0;
        logic        got_err = 1'b0, overlap = 1'b0, ready_early = 1'b0;

        err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        word      = refmem[addr[12:2]];
        exp_maddr = {addr[12:2], 2'b00};
        exp_wdata = refStore(word, wdata, addr, size);
        exp_rdata = (err || we) ? 32'd0 : refLoad(word, addr, size, uns);
        if (err) begin
            exp_rsp = 1; exp_rd = 0; exp_wr = 0; exp_wr_cyc = -1;
        end else if (we && size == 2'd2) begin
            exp_rsp = 2; exp_rd = 0; exp_wr = 1; exp_wr_cyc = 1;
        end else if (we) begin
            exp_rsp = 4 + extra; exp_rd = 1; exp_wr = 1; exp_wr_cyc = 3 + extra;
        end else begin
            exp_rsp = 3 + extra; exp_rd = 1; exp_wr = 0; exp_wr_cyc = -1;
        end

        extra_lat = extra;
        @(negedge clk);
        checkOutput("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = $urandom; req_addr = $urandom; req_size = $urandom;
        req_unsigned = $urandom; req_wdata = $urandom;

        addr_obs = exp_maddr;
        for (int c = 1; c <= 24; c++) begin
            if (mem_rd_en) rd_seen++;
            if (mem_wr_en) begin wr_seen++; wr_cyc = c; got_wd = mem_wr_data; end
            if (mem_rd_en && mem_wr_en) overlap = 1'b1;
            if (req_ready) ready_early = 1'b1;
            if (!err && mem_addr != exp_maddr) addr_obs = mem_addr;
            if (rsp_valid) begin
                rsp_cyc = c; got_err = rsp_err; got_rd = rsp_rdata;
                break;
            end
            @(posedge clk); #1;
        end

        checkOutput("rsp_cycle", rsp_cyc, exp_rsp);
        checkOutput("rsp_err", {31'd0, got_err}, {31'd0, err});
        checkOutput("rsp_rdata", got_rd, exp_rdata);
        checkOutput("rd_pulses", rd_seen, exp_rd);
        checkOutput("wr_pulses", wr_seen, exp_wr);
        checkOutput("wr_cycle", wr_cyc, exp_wr_cyc);
        checkOutput("rd_wr_overlap", {31'd0, overlap}, 32'd0);
        checkOutput("ready_busy", {31'd0, ready_early}, 32'd0);
        if (!err) checkOutput("mem_addr", {19'd0, addr_obs}, {19'd0, exp_maddr});
        if (we && !err) checkOutput("wr_data", got_wd, exp_wdata);

        @(posedge clk); #1;
        checkOutput("ready_after", {31'd0, req_ready}, 32'd1);
        checkOutput("rsp_valid_low", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rsp_err_low", {31'd0, rsp_err}, 32'd0);
        checkOutput("rdata_hold", rsp_rdata, exp_rdata);

        if (we && !err) refmem[addr[12:2]] = exp_wdata;
        last_rdata = got_rd;
        last_wdata = got_wd;
        last_err   = got_err;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
        checkOutput({tag, "_ctl"}, {28'd0, rsp_valid, rsp_err, mem_rd_en, mem_wr_en}, 32'd0);
        checkOutput({tag, "_rdata"}, rsp_rdata, 32'd0);
        checkOutput({tag, "_maddr"}, {19'd0, mem_addr}, 32'd0);
        checkOutput({tag, "_wdata"}, mem_wr_data, 32'd0);
    endtask

    initial begin
        int wr_during_rst;
        logic [1:0]  sz;
        logic [12:0] ad;

        for (int i = 0; i < 2048; i++) refmem[i] = initWord(i);
        $display("[TB] starting lsu bench");

        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("ready_post_reset", {31'd0, req_ready}, 32'd1);

        applyStimulus(1'b1, 13'h010, 2'd2, 1'b0, 32'h80FF7F01, 0);
        applyStimulus(1'b0, 13'h012, 2'd0, 1'b1, 32'd0, 0);
        checkOutput("plan_lbu_012", last_rdata, 32'h000000FF);
        applyStimulus(1'b0, 13'h012, 2'd0, 1'b0, 32'd0, 0);
        checkOutput("plan_lb_012", last_rdata, 32'hFFFFFFFF);
        applyStimulus(1'b0, 13'h010, 2'd0, 1'b0, 32'd0, 0);
        checkOutput("plan_lb_010", last_rdata, 32'h00000001);
        applyStimulus(1'b0, 13'h012, 2'd1, 1'b0, 32'd0, 0);
        checkOutput("plan_lh_012", last_rdata, 32'hFFFF80FF);
        applyStimulus(1'b0, 13'h010, 2'd1, 1'b1, 32'd0, 0);
        checkOutput("plan_lhu_010", last_rdata, 32'h00007F01);
        applyStimulus(1'b0, 13'h010, 2'd2, 1'b0, 32'd0, 2);
        checkOutput("plan_lw_010", last_rdata, 32'h80FF7F01);

        applyStimulus(1'b1, 13'h010, 2'd2, 1'b0, 32'h11223344, 0);
        applyStimulus(1'b1, 13'h011, 2'd0, 1'b0, 32'hFFFFFFAB, 0);
        checkOutput("plan_sb_merge", last_wdata, 32'h1122AB44);
        applyStimulus(1'b0, 13'h010, 2'd2, 1'b0, 32'd0, 0);
        checkOutput("plan_sb_readback", last_rdata, 32'h1122AB44);

        applyStimulus(1'b1, 13'h020, 2'd2, 1'b0, 32'hDEADBEEF, 0);
        applyStimulus(1'b1, 13'h022, 2'd1, 1'b0, 32'h00001234, 1);
        applyStimulus(1'b0, 13'h020, 2'd2, 1'b0, 32'd0, 0);
        checkOutput("plan_sh_readback", last_rdata, 32'h1234BEEF);

        applyStimulus(1'b0, 13'h005, 2'd2, 1'b0, 32'd0, 0);
        checkOutput("plan_err_lw", {31'd0, last_err}, 32'd1);
        applyStimulus(1'b1, 13'h003, 2'd1, 1'b0, 32'h5555AAAA, 0);
        checkOutput("plan_err_sh", {31'd0, last_err}, 32'd1);
        applyStimulus(1'b0, 13'h008, 2'd3, 1'b0, 32'd0, 0);
        checkOutput("plan_err_size3", {31'd0, last_err}, 32'd1);

        // Sub-word store cut off by reset while waiting on a slow read.
        extra_lat = 4;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 13'h031; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 32'h000000C3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkIdleOutputs("midreset");
        wr_during_rst = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (mem_wr_en) wr_during_rst++;
        end
        checkOutput("midreset_no_wr", wr_during_rst, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset_ready", {31'd0, req_ready}, 32'd1);
        applyStimulus(1'b0, 13'h030, 2'd2, 1'b0, 32'd0, 0);
        checkOutput("midreset_mem_kept", last_rdata, initWord(12));

        for (int n = 0; n < 200; n++) begin
            sz = 2'($urandom_range(0, 3));
            ad = 13'($urandom_range(0, 95));
            if ($urandom_range(0, 1) == 1) begin
                if (sz == 2'd1) ad[0] = 1'b0;
                if (sz == 2'd2) ad[1:0] = 2'b00;
            end
            applyStimulus(1'($urandom), ad, sz, 1'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
